// File: rtl/muldiv_unit_if.sv
// Request/result bundle between EX-stage control and the iterative multiply/divide unit.
// Control drives the request side; the unit drives busy/done and the HI/LO results.
interface muldiv_unit_if #(
    parameter int DATA_W = 32
);
    logic              enable;
    logic              start;
    logic [1:0]        op;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              div_zero;

    modport master (
        output enable, start, op, src_a, src_b,
        input  busy, done, hi, lo, div_zero
    );

    modport slave (
        input  enable, start, op, src_a, src_b,
        output busy, done, hi, lo, div_zero
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO; divider built only with MULDIV_DIV_EN defined.
// Latency DATA_W+1 enabled cycles (1 for divides without the divider); start while busy is dropped, enable low freezes all state.
module muldiv_unit #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] p_hi;
    logic [DATA_W-1:0] p_lo;
    logic [DATA_W-1:0] m;
    logic              is_div;
    logic              neg_q;
    logic              done_q;
    logic              div_zero_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic                b_zero;
    logic [DATA_W:0]     mul_sum;
    logic [2*DATA_W-1:0] prod_fix;

    assign a_neg    = bus.op[0] & bus.src_a[DATA_W-1];
    assign b_neg    = bus.op[0] & bus.src_b[DATA_W-1];
    assign a_mag    = a_neg ? -bus.src_a : bus.src_a;
    assign b_mag    = b_neg ? -bus.src_b : bus.src_b;
    assign b_zero   = (bus.src_b == '0);
    assign mul_sum  = {1'b0, p_hi} + {1'b0, m & {DATA_W{p_lo[0]}}};
    assign prod_fix = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};

`ifdef MULDIV_DIV_EN
    logic            neg_r;
    logic            dz_q;
    logic [DATA_W:0] rem_sh;
    logic [DATA_W:0] rem_nxt;
    logic            q_bit;

    assign rem_sh  = {p_hi, p_lo[DATA_W-1]};
    assign q_bit   = (rem_sh >= {1'b0, m});
    assign rem_nxt = q_bit ? (rem_sh - {1'b0, m}) : rem_sh;
`endif

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
        end else if (bus.enable) begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef MULDIV_DIV_EN
                    state_nxt = CALC;
`else
                    state_nxt = bus.op[1] ? FIX : CALC;
`endif
                end
            end
            CALC:    if (cnt == CNT_W'(DATA_W - 1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt        <= '0;
            p_hi       <= '0;
            p_lo       <= '0;
            m          <= '0;
            is_div     <= 1'b0;
            neg_q      <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
`ifdef MULDIV_DIV_EN
            neg_r      <= 1'b0;
            dz_q       <= 1'b0;
`endif
        end else if (bus.enable) begin
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt        <= '0;
                        is_div     <= bus.op[1];
                        neg_q      <= a_neg ^ b_neg;
                        p_hi       <= '0;
                        // A zero divisor keeps the raw dividend so it falls out as the remainder
                        p_lo       <= (bus.op[1] & b_zero) ? bus.src_a : a_mag;
                        m          <= b_mag;
                        div_zero_q <= 1'b0;
`ifdef MULDIV_DIV_EN
                        neg_r      <= a_neg;
                        dz_q       <= bus.op[1] & b_zero;
`endif
                    end
                end
                CALC: begin
                    cnt <= cnt + CNT_W'(1);
`ifdef MULDIV_DIV_EN
                    if (is_div) begin
                        p_hi <= rem_nxt[DATA_W-1:0];
                        p_lo <= {p_lo[DATA_W-2:0], q_bit};
                    end else begin
                        {p_hi, p_lo} <= {mul_sum, p_lo[DATA_W-1:1]};
                    end
`else
                    {p_hi, p_lo} <= {mul_sum, p_lo[DATA_W-1:1]};
`endif
                end
                FIX: begin
                    if (is_div) begin
`ifdef MULDIV_DIV_EN
                        if (dz_q) begin
                            hi_q       <= p_hi;
                            lo_q       <= p_lo;
                            div_zero_q <= 1'b1;
                        end else begin
                            hi_q <= neg_r ? -p_hi : p_hi;
                            lo_q <= neg_q ? -p_lo : p_lo;
                        end
`else
                        hi_q <= '0;
                        lo_q <= '0;
`endif
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit (DATA_W=32 and 8) against an arithmetic reference model.
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk;
    logic arst_n;
    int   total;
    int   bad;

    muldiv_unit_if #(.DATA_W(32)) bus ();
    muldiv_unit_if #(.DATA_W(8))  bus8 ();

    muldiv_unit #(.DATA_W(32)) dut   (.clk(clk), .arst_n(arst_n), .bus(bus));
    muldiv_unit #(.DATA_W(8))  dut8  (.clk(clk), .arst_n(arst_n), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // {div_zero, hi, lo} from plain arithmetic on the operands
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint      sa;
        longint      sb;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 2'd0) begin
            p = {32'd0, a} * {32'd0, b};
            return {1'b0, p};
        end
        if (op == 2'd1) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
`ifdef MULDIV_DIV_EN
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        if (op == 2'd2) return {1'b0, a % b, a / b};
        begin
            longint q;
            longint r;
            q = sa / sb;
            r = sa % sb;
            return {1'b0, r[31:0], q[31:0]};
        end
`else
        return '0;
`endif
    endfunction

    function automatic int exp_lat(input logic [1:0] op, input int w);
        return (op[1] && !DIV_EN) ? 1 : w + 1;
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [64:0] exp;
        int          cyc;
        int          bcnt;
        exp = model(op, a, b);
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc  = 0;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && cyc < 100) begin
            step();
            cyc++;
            if (bus.busy) bcnt++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'(exp_lat(op, 32)));
        check({tag, ".busy_cycles"}, 64'(bcnt), 64'(exp_lat(op, 32)));
        check({tag, ".hi"}, 64'(bus.hi), 64'(exp[63:32]));
        check({tag, ".lo"}, 64'(bus.lo), 64'(exp[31:0]));
        check({tag, ".div_zero"}, 64'(bus.div_zero), 64'(exp[64]));
    endtask

    task automatic run8(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input int lat, input logic [7:0] ehi, input logic [7:0] elo, input string tag);
        int cyc;
        bus8.op    = op;
        bus8.src_a = a;
        bus8.src_b = b;
        bus8.start = 1'b1;
        step();
        bus8.start = 1'b0;
        cyc = 0;
        while (!bus8.done && cyc < 50) begin
            step();
            cyc++;
        end
        check({tag, ".latency"}, 64'(cyc), 64'(lat));
        check({tag, ".hi"}, 64'(bus8.hi), 64'(ehi));
        check({tag, ".lo"}, 64'(bus8.lo), 64'(elo));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [64:0] exp;
        int          cyc;
        int          ndone;
        total = 0;
        bad   = 0;
        arst_n = 1'b0;
        bus.enable = 1'b1;  bus.start = 1'b0;  bus.op = 2'd0;  bus.src_a = '0;  bus.src_b = '0;
        bus8.enable = 1'b1; bus8.start = 1'b0; bus8.op = 2'd0; bus8.src_a = '0; bus8.src_b = '0;
        #1;
        check("reset.busy", 64'(bus.busy), 64'd0);
        check("reset.done", 64'(bus.done), 64'd0);
        check("reset.hi_lo", {bus.hi, bus.lo}, 64'd0);
        check("reset.div_zero", 64'(bus.div_zero), 64'd0);
        step();
        step();
        arst_n = 1'b1;
        step();

        run_op(2'd0, 32'hFFFF_FFFF, 32'd2, "multu_max_x2");
        step();
        check("done_single_cycle", 64'(bus.done), 64'd0);

        run_op(2'd1, 32'hFFFF_FFFD, 32'd5, "mult_m3_x5");
        run_op(2'd3, 32'hFFFF_FFF9, 32'd2, "div_m7_by2_b2b");

        run_op(2'd2, 32'd100, 32'd0, "divu_by_zero");
        bus.op = 2'd0; bus.src_a = 32'd1; bus.src_b = 32'd1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("div_zero_cleared_on_accept", 64'(bus.div_zero), 64'd0);
        cyc = 0;
        while (!bus.done && cyc < 100) begin step(); cyc++; end
        check("multu_1x1.lo", 64'(bus.lo), 64'd1);

        run_op(2'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");

        // ignored restart at cycle 5 and a 4-cycle enable drop at cycle 10
        exp = model(2'd0, 32'h1234_5678, 32'h0000_9ABC);
        bus.op = 2'd0; bus.src_a = 32'h1234_5678; bus.src_b = 32'h0000_9ABC; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = 2'd1; bus.src_a = 32'hDEAD_BEEF;
            end else begin
                bus.start = 1'b0;
            end
            if (cyc == 10) begin
                bus.enable = 1'b0;
                repeat (4) begin step(); cyc++; end
                check("frozen.busy", 64'(bus.busy), 64'd1);
                bus.enable = 1'b1;
            end
            step();
            cyc++;
        end
        check("stall.latency", 64'(cyc), 64'd37);
        check("stall.hi", 64'(bus.hi), 64'(exp[63:32]));
        check("stall.lo", 64'(bus.lo), 64'(exp[31:0]));

        // asynchronous reset mid-operation
        bus.op = 2'd0; bus.src_a = 32'd7; bus.src_b = 32'd9; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (20) step();
        arst_n = 1'b0;
        #1;
        check("midreset.busy", 64'(bus.busy), 64'd0);
        check("midreset.done", 64'(bus.done), 64'd0);
        check("midreset.hi_lo", {bus.hi, bus.lo}, 64'd0);
        check("midreset.div_zero", 64'(bus.div_zero), 64'd0);
        step();
        arst_n = 1'b1;
        ndone = 0;
        repeat (40) begin
            step();
            if (bus.done) ndone++;
        end
        check("midreset.no_done", 64'(ndone), 64'd0);

        for (int i = 0; i < 40; i++) begin
            logic [1:0] rop;
            rop = 2'($urandom_range(0, 3));
            run_op(rop, pick(), pick(), $sformatf("rand%0d", i));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
        end

        run8(2'd1, 8'h80, 8'h80, 9, 8'h40, 8'h00, "w8_mult_80x80");
        if (DIV_EN) run8(2'd2, 8'd100, 8'd7, 9, 8'd2, 8'd14, "w8_divu");
        else        run8(2'd2, 8'd100, 8'd7, 1, 8'd0, 8'd0, "w8_divu");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
